// File: rtl/mux2_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux2_rr_arbiter_pkg
// Description : Shared source encodings for the two-input round-robin arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mux2_rr_arbiter_pkg;

  // Encoding shared by the grant, the mux select and the last-grant bit.
  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  function automatic logic other_src(input logic src);
    return (src == SRC_A) ? SRC_B : SRC_A;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mux2_rr_arbiter_rr_pick2.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick2
// Description : Combinational two-way round-robin pick from valids and last grant.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick2
  import mux2_rr_arbiter_pkg::*;
(
  input  logic a_valid,
  input  logic b_valid,
  input  logic last,
  output logic gnt,
  output logic any_valid
);

  always_comb begin
    gnt       = SRC_A;
    any_valid = a_valid | b_valid;
    unique case ({a_valid, b_valid})
      2'b10:   gnt = SRC_A;
      2'b01:   gnt = SRC_B;
      // A tie goes to whichever source did not win the previous handshake.
      2'b11:   gnt = other_src(last);
      default: gnt = SRC_A;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mux2_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mux2_rr_arbiter
// Description : Two-channel round-robin arbiter with a registered output word
//               and select for a downstream 2:1 mux, plus a saturating
//               transfer counter.
// Revision    : 1.0 - initial release
// ============================================================================
module mux2_rr_arbiter
  import mux2_rr_arbiter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             sel,
  output logic [CNT_W-1:0] xfer_cnt
);

  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_sel;
  logic             r_last;
  logic [CNT_W-1:0] r_xfer_cnt;

  logic             w_gnt;
  logic             w_any_valid;
  logic             w_load;
  logic             w_drain;

  rr_pick2 u_pick (
    .a_valid   (a_valid),
    .b_valid   (b_valid),
    .last      (r_last),
    .gnt       (w_gnt),
    .any_valid (w_any_valid)
  );

  assign w_load  = ~r_out_valid | out_ready;
  assign w_drain = r_out_valid & out_ready;

  // Readies are masked while reset is held so no word is consumed then.
  assign a_ready = rst_n & w_load & a_valid & (w_gnt == SRC_A);
  assign b_ready = rst_n & w_load & b_valid & (w_gnt == SRC_B);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_sel       <= SRC_A;
      r_last      <= SRC_B;
    end else if (w_load) begin
      if (w_any_valid) begin
        r_out_valid <= 1'b1;
        r_out_data  <= (w_gnt == SRC_B) ? b_data : a_data;
        r_sel       <= w_gnt;
        r_last      <= w_gnt;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_xfer_cnt <= '0;
    end else if (w_drain && (r_xfer_cnt != c_cnt_max)) begin
      r_xfer_cnt <= r_xfer_cnt + 1'b1;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign sel       = r_sel;
  assign xfer_cnt  = r_xfer_cnt;

endmodule
`default_nettype wire
